// File: rtl/tomasulo_pkg.sv
// Shared definitions for the instruction issue front end.
// Holds the opcode and funct field constants, the reservation-station class
// and operation encodings, the issue-queue FSM state enum, and the decoder
// that maps a 32-bit instruction word onto issue fields.
package tomasulo_pkg;

   localparam logic [6:0] OPC_LW     = 7'b0000011;
   localparam logic [6:0] OPC_ALU    = 7'b0110011;
   localparam logic [6:0] OPC_MULDIV = 7'b1100011;
   localparam logic [6:0] OPC_HALT   = 7'b0010100;

   localparam logic [6:0] F7_ADD     = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;
   localparam logic [2:0] F3_MUL     = 3'b000;
   localparam logic [2:0] F3_DIV     = 3'b001;

   typedef enum logic [1:0] {
      CLS_LOAD   = 2'd0,
      CLS_ADDSUB = 2'd1,
      CLS_MULDIV = 2'd2
   } iclass_t;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_MUL = 3'd3,
      OP_DIV = 3'd4
   } iop_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   typedef struct packed {
      logic        legal;
      logic        halt;
      iclass_t     cls;
      iop_t        op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm;
   } dec_t;

   // Register fields are always taken from their fixed bit positions;
   // only LW carries an immediate, everything else reports zero.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d.legal = 1'b1;
      d.halt  = 1'b0;
      d.cls   = CLS_LOAD;
      d.op    = OP_LW;
      d.rd    = w[11:7];
      d.rs1   = w[19:15];
      d.rs2   = w[24:20];
      d.imm   = '0;
      case (w[6:0])
         OPC_LW: begin
            d.imm = w[31:20];
         end
         OPC_ALU: begin
            d.cls = CLS_ADDSUB;
            if (w[31:25] == F7_ADD)      d.op = OP_ADD;
            else if (w[31:25] == F7_SUB) d.op = OP_SUB;
            else                         d.legal = 1'b0;
         end
         OPC_MULDIV: begin
            d.cls = CLS_MULDIV;
            if (w[31:25] == F7_MULDIV && w[14:12] == F3_MUL)      d.op = OP_MUL;
            else if (w[31:25] == F7_MULDIV && w[14:12] == F3_DIV) d.op = OP_DIV;
            else                                                  d.legal = 1'b0;
         end
         OPC_HALT: begin
            d.halt = 1'b1;
         end
         default: begin
            d.legal = 1'b0;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch and issue bus of the issue queue.
//   pc            fetch address toward the fetch stage
//   inst_in       fetched word, valid one cycle after pc
//   rs_free       per-class free-slot flags (bit0 LOAD, bit1 ADDSUB, bit2 MULDIV)
//   issue_*       decoded instruction presented to the reservation stations
//   halted        sticky HALT-reached flag
//   illegal       one-cycle pulse when an unrecognised word is dropped
// The master modport is the issue queue itself; slave is the surrounding
// fetch/reservation-station side.
interface issue_queue_if #(
   parameter int PCW = 7
);
   logic [PCW-1:0] pc;
   logic [31:0]    inst_in;
   logic [2:0]     rs_free;
   logic           issue_valid;
   logic [1:0]     issue_class;
   logic [2:0]     issue_op;
   logic [4:0]     issue_rd;
   logic [4:0]     issue_rs1;
   logic [4:0]     issue_rs2;
   logic [11:0]    issue_imm;
   logic           halted;
   logic           illegal;

   modport master (
      output pc, issue_valid, issue_class, issue_op, issue_rd, issue_rs1,
             issue_rs2, issue_imm, halted, illegal,
      input  inst_in, rs_free
   );

   modport slave (
      input  pc, issue_valid, issue_class, issue_op, issue_rd, issue_rs1,
             issue_rs2, issue_imm, halted, illegal,
      output inst_in, rs_free
   );
endinterface

// File: rtl/inst_fifo.sv
// Instruction FIFO behind the fetch stage.
//   clk1   clock, rising edge
//   rst    asynchronous active-high reset (pointers and count only)
//   flush  synchronous empty, has priority over push/pop
//   push   write din at the tail
//   din    instruction word
//   pop    drop the head entry
//   dout   head entry (meaningful while not empty)
//   count  number of valid entries, 0..DEPTH
//   empty  count == 0
// The caller guarantees no push when full and no pop when empty.
module inst_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk1,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries covered by count are ever read.
   always_ff @(posedge clk1) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/issue_queue.sv
// In-order fetch/decode/issue front end.
// A PC counter requests one word per cycle while the queue plus the one
// outstanding request still fit; the returned word is captured a cycle later
// into inst_fifo, and the head is decoded combinationally and issued to the
// reservation station of its class when that class has a free slot.
// Ports:
//   clk1  clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   issue_queue_if master: pc/inst_in fetch side, rs_free and
//         issue_* toward the reservation stations, halted/illegal status
module issue_queue
   import tomasulo_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int PCW    = 7
) (
   input  logic          clk1,
   input  logic          rst,
   issue_queue_if.master bus
);
   localparam int AW = $clog2(QDEPTH);

   logic [PCW-1:0] pc_q;
   logic           vld_p1;
   state_t         state;
   logic           halted_q;

   logic [31:0]    head;
   logic [AW:0]    fifo_cnt;
   logic           fifo_empty;
   logic [AW+1:0]  occ;
   dec_t           dec;

   logic fetch_req, push, pop, flush;
   logic head_vld, cls_free, show, do_issue, halt_pop, ill_pop;

   // Fetch stage: request while entries held plus the outstanding request
   // leave room, so the FIFO can never overflow.
   assign occ       = {1'b0, fifo_cnt} + (AW+2)'(vld_p1);
   assign fetch_req = (state == ST_RUN) && (occ < (AW+2)'(QDEPTH));

   // Capture stage: an all-zero word is a fetch bubble and is dropped. A word
   // arriving on the edge that retires HALT is younger than HALT and is lost.
   assign push  = vld_p1 && (state == ST_RUN) && !halt_pop && (bus.inst_in != '0);
   assign flush = halt_pop || (state != ST_RUN);

   inst_fifo #(
      .DEPTH (QDEPTH),
      .W     (32)
   ) u_fifo (
      .clk1  (clk1),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .din   (bus.inst_in),
      .pop   (pop),
      .dout  (head),
      .count (fifo_cnt),
      .empty (fifo_empty)
   );

   // Issue stage: decode the head, then issue, retire HALT or drop illegal.
   assign dec      = decode(head);
   assign head_vld = !fifo_empty && (state == ST_RUN);

   always_comb begin
      cls_free = 1'b0;
      case (dec.cls)
         CLS_LOAD:   cls_free = bus.rs_free[0];
         CLS_ADDSUB: cls_free = bus.rs_free[1];
         CLS_MULDIV: cls_free = bus.rs_free[2];
         default:    cls_free = 1'b0;
      endcase
   end

   assign show     = head_vld && dec.legal && !dec.halt;
   assign do_issue = show && cls_free;
   assign halt_pop = head_vld && dec.legal && dec.halt;
   assign ill_pop  = head_vld && !dec.legal;
   assign pop      = do_issue || halt_pop || ill_pop;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state    <= ST_RUN;
         halted_q <= 1'b0;
         pc_q     <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= fetch_req;
         if (fetch_req) pc_q <= pc_q + PCW'(1);
         case (state)
            ST_RUN: begin
               if (halt_pop) begin
                  state    <= ST_DRAIN;
                  halted_q <= 1'b1;
               end
            end
            ST_DRAIN: state <= ST_HALT;
            ST_HALT:  state <= ST_HALT;
            default:  state <= ST_RUN;
         endcase
      end
   end

   // Fields stay visible while a legal head is stalled on rs_free.
   assign bus.pc          = pc_q;
   assign bus.issue_valid = do_issue;
   assign bus.issue_class = show ? dec.cls : 2'd0;
   assign bus.issue_op    = show ? dec.op  : 3'd0;
   assign bus.issue_rd    = show ? dec.rd  : 5'd0;
   assign bus.issue_rs1   = show ? dec.rs1 : 5'd0;
   assign bus.issue_rs2   = show ? dec.rs2 : 5'd0;
   assign bus.issue_imm   = show ? dec.imm : 12'd0;
   assign bus.halted      = halted_q;
   assign bus.illegal     = ill_pop;

endmodule
